// File: rtl/gemm_tile_scheduler.sv
// Tile-loop controller for one GEMM job: walks weight/tensor/K loops, issues
// multiply requests, waits for completion and holds off for the result drain.
module gemm_tile_scheduler #(
  parameter int S2P_SIZE = 4,
  parameter int K_W      = 12,
  parameter int T_W      = 13,
  parameter int W_W      = 8
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           start,
  input  logic           abort,
  input  logic [K_W-1:0] k_last,
  input  logic [T_W-1:0] t_tiles,
  input  logic [W_W-1:0] w_tiles,
  output logic           mul_start,
  input  logic           mul_done,
  output logic [K_W-1:0] k_idx,
  output logic [T_W-1:0] t_idx,
  output logic [W_W-1:0] w_idx,
  output logic           tensor_done,
  output logic           weight_done,
  output logic           busy,
  output logic           job_done
);

  // state  | meaning
  // IDLE   | waiting for start, descriptor may change freely
  // ISSUE  | one-cycle multiply request for current (k,t,w)
  // WAIT   | waiting for the multiplier completion pulse
  // DRAIN  | result shift-out window after the last chunk of a tile
  // DONE   | one-cycle job completion
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_DONE} state_t;

  localparam int DN = S2P_SIZE * S2P_SIZE;
  localparam int DW = (DN > 1) ? $clog2(DN) : 1;

  state_t         state_q, state_d;
  logic [K_W-1:0] k_q, k_d, kl_q, kl_d;
  logic [T_W-1:0] t_q, t_d, tt_q, tt_d;
  logic [W_W-1:0] w_q, w_d, wt_q, wt_d;
  logic [DW-1:0]  drain_q, drain_d;

  logic t_at_last, w_at_last;

  assign t_at_last = (t_q == tt_q - T_W'(1));
  assign w_at_last = (w_q == wt_q - W_W'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      t_q     <= '0;
      w_q     <= '0;
      kl_q    <= '0;
      tt_q    <= '0;
      wt_q    <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      t_q     <= t_d;
      w_q     <= w_d;
      kl_q    <= kl_d;
      tt_q    <= tt_d;
      wt_q    <= wt_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    t_d     = t_q;
    w_d     = w_q;
    kl_d    = kl_q;
    tt_d    = tt_q;
    wt_d    = wt_q;
    drain_d = drain_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          kl_d    = k_last;
          tt_d    = t_tiles;
          wt_d    = w_tiles;
          k_d     = '0;
          t_d     = '0;
          w_d     = '0;
          state_d = (t_tiles == '0 || w_tiles == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (mul_done) begin
          if (k_q < kl_q) begin
            k_d     = k_q + K_W'(1);
            state_d = S_ISSUE;
          end else begin
            k_d     = '0;
            drain_d = DW'(DN - 1);
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) begin
          if (t_at_last && w_at_last) begin
            state_d = S_DONE;
          end else begin
            if (t_at_last) begin
              t_d = '0;
              w_d = w_q + W_W'(1);
            end else begin
              t_d = t_q + T_W'(1);
            end
            state_d = S_ISSUE;
          end
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      S_DONE: begin
        k_d     = '0;
        t_d     = '0;
        w_d     = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
      k_d     = '0;
      t_d     = '0;
      w_d     = '0;
      drain_d = '0;
    end
  end

  // Pulses are suppressed combinationally in an abort cycle.
  assign mul_start   = (state_q == S_ISSUE) && !abort;
  assign tensor_done = mul_start && (k_q == '0) && t_at_last;
  assign weight_done = tensor_done && w_at_last;
  assign job_done    = (state_q == S_DONE) && !abort;
  assign busy        = (state_q != S_IDLE);
  assign k_idx       = k_q;
  assign t_idx       = t_q;
  assign w_idx       = w_q;

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Randomized bench for gemm_tile_scheduler against a loop-nest/timing model.
module tb_gemm_tile_scheduler;
  localparam int S2P = 4;
  localparam int KW  = 12;
  localparam int TW  = 13;
  localparam int WW  = 8;
  localparam int DN  = S2P * S2P;

  logic          clk = 0;
  logic          rstn = 0;
  logic          start = 0, abort = 0, mul_done = 0;
  logic [KW-1:0] k_last = '0;
  logic [TW-1:0] t_tiles = '0;
  logic [WW-1:0] w_tiles = '0;
  logic          mul_start, tensor_done, weight_done, busy, job_done;
  logic [KW-1:0] k_idx;
  logic [TW-1:0] t_idx;
  logic [WW-1:0] w_idx;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int k;
    int t;
    int w;
    bit td;
    bit wd;
  } iss_t;

  gemm_tile_scheduler #(.S2P_SIZE(S2P), .K_W(KW), .T_W(TW), .W_W(WW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .k_last(k_last), .t_tiles(t_tiles), .w_tiles(w_tiles),
    .mul_start(mul_start), .mul_done(mul_done),
    .k_idx(k_idx), .t_idx(t_idx), .w_idx(w_idx),
    .tensor_done(tensor_done), .weight_done(weight_done),
    .busy(busy), .job_done(job_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] all_out();
    return {mul_start, tensor_done, weight_done, job_done, busy, k_idx, t_idx, w_idx};
  endfunction

  // mode 0: normal, 1: abort with mul_done of issue #at, 2: abort mid-ISSUE #at,
  // 3: rstn pulse inside the drain following issue #at. fixed_d>0 pins mul_done latency.
  task automatic run_job(input int kl, input int tt, input int wt,
                         input int mode, input int at, input int fixed_d);
    iss_t q[$];
    int c = 0, nxt = 1, done_cyc = -1, end_cyc = -1, n_iss = 0;
    bit waiting = 0, last_k = 0, stop = 0;
    logic exp_ms, exp_jd, exp_td, exp_wd, exp_busy;
    for (int w = 0; w < wt; w++)
      for (int t = 0; t < tt; t++)
        for (int k = 0; k <= kl; k++) begin
          iss_t e;
          e.k = k; e.t = t; e.w = w;
          e.td = (k == 0) && (t == tt - 1);
          e.wd = e.td && (w == wt - 1);
          q.push_back(e);
        end
    k_last = KW'(kl); t_tiles = TW'(tt); w_tiles = WW'(wt); start = 1;
    while (!stop) begin
      @(negedge clk); c++;
      start = 0; abort = 0; mul_done = 0;
      k_last = KW'($urandom); t_tiles = TW'($urandom); w_tiles = WW'($urandom);
      if (end_cyc >= 0) begin
        chk("post_done", all_out(), 64'd0);
        stop = 1;
      end else begin
        exp_ms = (c == nxt) && (q.size() > 0);
        exp_jd = (c == nxt) && (q.size() == 0);
        exp_td = exp_ms ? q[0].td : 1'b0;
        exp_wd = exp_ms ? q[0].wd : 1'b0;
        exp_busy = 1'b1;
        chk("pulses", {mul_start, tensor_done, weight_done, job_done, busy},
            {exp_ms, exp_td, exp_wd, exp_jd, exp_busy});
        if (exp_jd) end_cyc = c;
        if (exp_ms) begin
          chk("idx", {k_idx, t_idx, w_idx}, {KW'(q[0].k), TW'(q[0].t), WW'(q[0].w)});
          last_k = (q[0].k == kl);
          void'(q.pop_front());
          n_iss++;
          waiting = 1;
          done_cyc = c + ((fixed_d > 0) ? fixed_d : int'($urandom_range(1, 4)));
          if (mode == 2 && n_iss == at) begin
            #1 abort = 1;
            #1 chk("abort_gate", {mul_start, tensor_done, weight_done, job_done}, 64'd0);
            stop = 1;
          end
        end else if (waiting && c == done_cyc) begin
          mul_done = 1;
          waiting = 0;
          nxt = last_k ? c + DN + 1 : c + 1;
          if (mode == 1 && n_iss == at) begin
            abort = 1;
            stop = 1;
          end
        end else if (!waiting && $urandom_range(0, 3) == 0) begin
          mul_done = 1;
        end
        if (mode == 3 && n_iss == at && !waiting && last_k && c == nxt - 5) begin
          #1 rstn = 0;
          #1 chk("rst_async", all_out(), 64'd0);
          repeat (2) begin
            @(negedge clk);
            chk("rst_hold", all_out(), 64'd0);
          end
          rstn = 1;
          stop = 1;
        end
        if (c > 3000) begin
          chk("timeout", 64'd0, 64'd1);
          stop = 1;
        end
      end
    end
    if (mode == 1 || mode == 2) begin
      repeat (4) begin
        @(negedge clk);
        abort = 0; mul_done = 1'($urandom_range(0, 1));
        chk("after_abort", all_out(), 64'd0);
      end
      mul_done = 0;
    end
  endtask

  initial begin
    #1 chk("reset", all_out(), 64'd0);
    @(negedge clk);
    chk("reset_hold", all_out(), 64'd0);
    rstn = 1;
    @(negedge clk);

    run_job(0, 1, 1, 0, 0, 4);   // mul_done@5, job_done@22
    run_job(2, 2, 1, 0, 0, 3);
    run_job(0, 3, 2, 0, 0, 0);
    run_job(1, 0, 3, 0, 0, 0);   // empty job
    run_job(2, 3, 0, 0, 0, 0);   // empty job
    run_job(3, 2, 2, 1, 2, 0);   // abort in WAIT with mul_done of chunk 2
    run_job(3, 2, 2, 0, 0, 0);
    run_job(1, 2, 2, 2, 3, 0);   // abort during ISSUE
    run_job(1, 2, 2, 3, 2, 0);   // reset inside drain
    @(negedge clk);
    run_job(1, 2, 1, 0, 0, 0);

    start = 1; abort = 1;
    @(negedge clk);
    start = 0; abort = 0;
    chk("start_abort", all_out(), 64'd0);

    for (int i = 0; i < 20; i++) begin
      int kl, tt, wt;
      kl = $urandom_range(0, 3);
      tt = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3));
      wt = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3));
      run_job(kl, tt, wt, 0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
